// File: rtl/sobel_frame_sequencer.sv
// Frame sequencer for the sobel engine: streams a source frame into the
// engine over a simple cyc/stb/ack bus, kicks processing, then reads the
// result frame back and writes it to the result memory.
module sobel_frame_sequencer #(
  parameter logic [21:0] LOAD_LAST_ADR = 22'h4B000,
  parameter logic [21:0] READ_LAST_ADR = 22'h4AB00,
  parameter int unsigned ACK_TIMEOUT   = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        go_i,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        err_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [21:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  output logic        start_o,
  input  logic        done_i,
  output logic        src_rd_o,
  output logic [21:0] src_adr_o,
  input  logic [31:0] src_dat_i,
  output logic        snk_we_o,
  output logic [21:0] snk_adr_o,
  output logic [31:0] snk_dat_o
);

  typedef enum logic [3:0] {
    IDLE, LD_FETCH, LD_WAIT, LD_REQ, RUN, RD_REQ, RD_STORE, DONE, ERR
  } state_t;

  // Wait counter only has to reach ACK_TIMEOUT-1 before the block gives up.
  localparam int WW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(ACK_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [21:0]     cnt_q;
  logic [WW-1:0]   wait_q;
  logic [31:0]     rd_word_q;
  logic            wait_expired;

  // An ack on the last allowed strobe cycle still wins over the timeout.
  assign wait_expired = (wait_q == WAIT_LAST);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; go_i is only honoured from IDLE and ERR.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (go_i) state_d = LD_FETCH;
      LD_FETCH: state_d = LD_WAIT;
      LD_WAIT:  state_d = LD_REQ;
      LD_REQ: begin
        if (ack_i)             state_d = (cnt_q == LOAD_LAST_ADR) ? RUN : LD_FETCH;
        else if (wait_expired) state_d = ERR;
      end
      RUN:      if (done_i) state_d = RD_REQ;
      RD_REQ: begin
        if (ack_i)             state_d = RD_STORE;
        else if (wait_expired) state_d = ERR;
      end
      RD_STORE: state_d = (cnt_q == READ_LAST_ADR) ? DONE : RD_REQ;
      DONE:     state_d = IDLE;
      ERR:      if (go_i) state_d = LD_FETCH;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath: address counter (compare before increment, so it never wraps),
  // write-data holding register, read capture and ack wait counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      wait_q    <= '0;
      dat_o     <= '0;
      rd_word_q <= '0;
    end else begin
      if ((state_q == IDLE || state_q == ERR) && go_i)
        cnt_q <= '0;
      else if (state_q == LD_REQ && ack_i)
        cnt_q <= (cnt_q == LOAD_LAST_ADR) ? 22'd0 : cnt_q + 22'd4;
      else if (state_q == RD_STORE && cnt_q != READ_LAST_ADR)
        cnt_q <= cnt_q + 22'd4;

      if (state_q == LD_WAIT) dat_o <= src_dat_i;
      if (state_q == RD_REQ && ack_i) rd_word_q <= dat_i;

      if (state_d != state_q) wait_q <= '0;
      else if (stb_o)         wait_q <= wait_q + 1'b1;
    end
  end

  // Moore outputs; cyc_o stays up between load beats but not before the first.
  always_comb begin
    busy_o       = !(state_q inside {IDLE, ERR});
    frame_done_o = (state_q == DONE);
    err_o        = (state_q == ERR);
    stb_o        = (state_q == LD_REQ) || (state_q == RD_REQ);
    cyc_o        = (state_q inside {LD_WAIT, LD_REQ, RD_REQ, RD_STORE}) ||
                   (state_q == LD_FETCH && cnt_q != '0);
    we_o         = cyc_o && (state_q inside {LD_FETCH, LD_WAIT, LD_REQ});
    adr_o        = stb_o ? cnt_q : '0;
    start_o      = (state_q == RUN);
    src_rd_o     = (state_q == LD_FETCH);
    src_adr_o    = src_rd_o ? cnt_q : '0;
    snk_we_o     = (state_q == RD_STORE);
    snk_adr_o    = snk_we_o ? cnt_q : '0;
    snk_dat_o    = snk_we_o ? rd_word_q : '0;
  end

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Bench for sobel_frame_sequencer: behavioural source memory, sobel bus
// responder and result memory, with per-frame transaction logs compared
// against the expected frame contents.
module tb_sobel_frame_sequencer;
  localparam int LL  = 12;
  localparam int RL  = 8;
  localparam int TO  = 8;
  localparam int NLD = LL / 4 + 1;
  localparam int NRD = RL / 4 + 1;

  logic        clk = 1'b0;
  logic        rst_i, go_i, ack_i, done_i;
  logic [31:0] dat_i, src_dat_i;
  logic        busy_o, frame_done_o, err_o, cyc_o, stb_o, we_o, start_o;
  logic        src_rd_o, snk_we_o;
  logic [21:0] adr_o, src_adr_o, snk_adr_o;
  logic [31:0] dat_o, snk_dat_o;
  logic [138:0] all_outs;

  always #5 clk = ~clk;

  sobel_frame_sequencer #(
    .LOAD_LAST_ADR(22'd12), .READ_LAST_ADR(22'd8), .ACK_TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .go_i(go_i), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .err_o(err_o), .cyc_o(cyc_o), .stb_o(stb_o),
    .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i),
    .start_o(start_o), .done_i(done_i), .src_rd_o(src_rd_o),
    .src_adr_o(src_adr_o), .src_dat_i(src_dat_i), .snk_we_o(snk_we_o),
    .snk_adr_o(snk_adr_o), .snk_dat_o(snk_dat_o)
  );

  assign all_outs = {busy_o, frame_done_o, err_o, cyc_o, stb_o, we_o, adr_o,
                     dat_o, start_o, src_rd_o, src_adr_o, snk_we_o, snk_adr_o,
                     snk_dat_o};

  int checks = 0;
  int errors = 0;

  logic [31:0] src_mem [NLD];
  logic [31:0] res_mem [NRD];

  // responder configuration
  int delay_mode;    // <0: random 0..4 per beat, else fixed ack delay
  int withhold_adr;  // load address never acked, <0 for none
  bit spurious;      // stray ack/done outside their windows
  bit go_in_run;     // pulse go while the engine is running

  // responder / observation state
  bit          pend;
  logic [21:0] pend_adr;
  int          stb_cnt, beat_delay, last_stb_len;
  logic [21:0] s_adr;
  logic [31:0] s_dat;
  logic        s_we;
  int          start_cnt, loads_at_start, fdone_cnt;
  bit          start_seen, done_sent, drop_checked;
  logic [21:0] ld_adr_q[$];
  logic [31:0] ld_dat_q[$];
  logic [21:0] rd_adr_q[$];
  logic [21:0] sk_adr_q[$];
  logic [31:0] sk_dat_q[$];

  task automatic clear_logs();
    ld_adr_q.delete(); ld_dat_q.delete(); rd_adr_q.delete();
    sk_adr_q.delete(); sk_dat_q.delete();
    pend = 0; stb_cnt = 0; last_stb_len = 0; start_cnt = 0;
    loads_at_start = 0; fdone_cnt = 0; start_seen = 0; done_sent = 0;
    drop_checked = 0;
  endtask

  // One clock: wait for the falling edge, observe outputs, drive inputs.
  task automatic step();
    int  idx;
    bit  hold;
    @(negedge clk);
    go_i = 1'b0;
    // source memory with one cycle of read latency
    if (src_rd_o) begin
      checks++;
      if (pend) begin
        errors++;
        $display("FAIL src_rd_pulse got two-cycle strobe adr=%h want single cycle", src_adr_o);
      end
    end
    idx = int'(pend_adr) / 4;
    src_dat_i = (pend && idx < NLD) ? src_mem[idx] : $urandom;
    pend = src_rd_o;
    pend_adr = src_adr_o;
    // sobel bus slave
    ack_i = 1'b0;
    dat_i = $urandom;
    if (stb_o) begin
      if (stb_cnt == 0) begin
        s_adr = adr_o; s_dat = dat_o; s_we = we_o;
        beat_delay = (delay_mode < 0) ? int'($urandom_range(0, 4)) : delay_mode;
      end else begin
        checks++;
        if (adr_o !== s_adr || dat_o !== s_dat || we_o !== s_we || cyc_o !== 1'b1) begin
          errors++;
          $display("FAIL stb_hold got adr=%h dat=%h we=%b cyc=%b want adr=%h dat=%h we=%b cyc=1",
                   adr_o, dat_o, we_o, cyc_o, s_adr, s_dat, s_we);
        end
      end
      hold = s_we && (withhold_adr >= 0) && (int'(s_adr) == withhold_adr);
      if (stb_cnt == beat_delay && !hold) begin
        ack_i = 1'b1;
        if (s_we) begin
          ld_adr_q.push_back(s_adr);
          ld_dat_q.push_back(s_dat);
        end else begin
          rd_adr_q.push_back(s_adr);
          idx = int'(s_adr) / 4;
          dat_i = (idx < NRD) ? res_mem[idx] : 32'hBAD0_0000;
        end
      end
      stb_cnt++;
    end else begin
      if (stb_cnt > 0) last_stb_len = stb_cnt;
      stb_cnt = 0;
      if (spurious) ack_i = ($urandom_range(0, 3) == 0);
    end
    // engine start/done handshake
    done_i = 1'b0;
    if (done_sent && !drop_checked) begin
      drop_checked = 1;
      checks++;
      if (start_o !== 1'b0) begin
        errors++;
        $display("FAIL start_drop got start_o=%b want 0", start_o);
      end
    end
    if (start_o) begin
      if (!start_seen) begin
        start_seen = 1;
        loads_at_start = ld_adr_q.size();
      end
      start_cnt++;
      if (go_in_run && start_cnt == 2) go_i = 1'b1;
      if (start_cnt == 5 && !done_sent) begin
        done_i = 1'b1;
        done_sent = 1;
      end
    end else if (spurious) begin
      done_i = ($urandom_range(0, 3) == 0);
    end
    // result memory
    if (snk_we_o) begin
      sk_adr_q.push_back(snk_adr_o);
      sk_dat_q.push_back(snk_dat_o);
    end
    fdone_cnt += int'(frame_done_o);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; go_i = 1'b1; ack_i = 1'b0; done_i = 1'b0;
    dat_i = '0; src_dat_i = '0;
    delay_mode = 0; withhold_adr = -1; spurious = 0; go_in_run = 0;
    clear_logs();
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL reset_outs got %h want 0", all_outs);
    end
    rst_i = 1'b0; go_i = 1'b0;
    repeat (6) step();
    checks++;
    if (all_outs !== '0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_go got outs=%h want 0", all_outs);
    end
  endtask

  // Full frame; the expected frame is every load address 0..LL with its
  // source word, engine started after the last load, and every result
  // address 0..RL read back and stored with the engine's word.
  task automatic test_frame(input string name, input int dmode, input bit spur,
                            input bit go_run);
    int n;
    for (int i = 0; i < NLD; i++)
      src_mem[i] = (dmode == 0 && !spur) ? 32'(4 * i) : $urandom;
    for (int i = 0; i < NRD; i++) res_mem[i] = $urandom;
    clear_logs();
    delay_mode = dmode; spurious = spur; go_in_run = go_run; withhold_adr = -1;
    go_i = 1'b1;
    n = 0;
    while (fdone_cnt == 0 && err_o !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    repeat (3) step();
    spurious = 0; go_in_run = 0;
    checks++;
    if (ld_adr_q.size() != NLD) begin
      errors++;
      $display("FAIL %s load_count got %0d want %0d", name, ld_adr_q.size(), NLD);
    end
    for (int i = 0; i < NLD; i++) begin
      checks++;
      if (i >= ld_adr_q.size() || ld_adr_q[i] !== 22'(4 * i) || ld_dat_q[i] !== src_mem[i]) begin
        errors++;
        $display("FAIL %s load[%0d] got adr=%h dat=%h want adr=%h dat=%h", name, i,
                 (i < ld_adr_q.size()) ? ld_adr_q[i] : 22'h3FFFFF,
                 (i < ld_dat_q.size()) ? ld_dat_q[i] : 32'hFFFFFFFF, 22'(4 * i), src_mem[i]);
      end
    end
    checks++;
    if (!start_seen || loads_at_start != NLD || !drop_checked) begin
      errors++;
      $display("FAIL %s start got seen=%0d loads=%0d dropped=%0d want 1 %0d 1", name,
               start_seen, loads_at_start, drop_checked, NLD);
    end
    checks++;
    if (rd_adr_q.size() != NRD || sk_adr_q.size() != NRD) begin
      errors++;
      $display("FAIL %s read_count got rd=%0d sk=%0d want %0d", name, rd_adr_q.size(),
               sk_adr_q.size(), NRD);
    end
    for (int i = 0; i < NRD; i++) begin
      checks++;
      if (i >= sk_adr_q.size() || i >= rd_adr_q.size() || rd_adr_q[i] !== 22'(4 * i) ||
          sk_adr_q[i] !== 22'(4 * i) || sk_dat_q[i] !== res_mem[i]) begin
        errors++;
        $display("FAIL %s store[%0d] got adr=%h dat=%h want adr=%h dat=%h", name, i,
                 (i < sk_adr_q.size()) ? sk_adr_q[i] : 22'h3FFFFF,
                 (i < sk_dat_q.size()) ? sk_dat_q[i] : 32'hFFFFFFFF, 22'(4 * i), res_mem[i]);
      end
    end
    checks++;
    if (fdone_cnt != 1 || busy_o !== 1'b0 || err_o !== 1'b0 || cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL %s end got done_pulses=%0d busy=%b err=%b cyc=%b want 1 0 0 0", name,
               fdone_cnt, busy_o, err_o, cyc_o);
    end
  endtask

  task automatic test_timeout();
    int n;
    for (int i = 0; i < NLD; i++) src_mem[i] = $urandom;
    for (int i = 0; i < NRD; i++) res_mem[i] = $urandom;
    clear_logs();
    delay_mode = 0; withhold_adr = 8; spurious = 0; go_in_run = 0;
    go_i = 1'b1;
    n = 0;
    while (err_o !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (err_o !== 1'b1 || cyc_o !== 1'b0 || stb_o !== 1'b0 || start_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_state got err=%b cyc=%b stb=%b start=%b busy=%b want 1 0 0 0 0",
               err_o, cyc_o, stb_o, start_o, busy_o);
    end
    checks++;
    if (last_stb_len != TO || ld_adr_q.size() != 2) begin
      errors++;
      $display("FAIL timeout_len got stb_cycles=%0d loads=%0d want %0d 2", last_stb_len,
               ld_adr_q.size(), TO);
    end
    repeat (5) step();
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky got err=%b busy=%b want 1 0", err_o, busy_o);
    end
    // restart from ERR
    clear_logs();
    withhold_adr = -1;
    go_i = 1'b1;
    step();
    checks++;
    if (err_o !== 1'b0 || src_rd_o !== 1'b1 || src_adr_o !== 22'd0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL restart got err=%b src_rd=%b src_adr=%h busy=%b want 0 1 0 1",
               err_o, src_rd_o, src_adr_o, busy_o);
    end
    n = 0;
    while (fdone_cnt == 0 && n < 400) begin
      step();
      n++;
    end
    step();
    checks++;
    if (fdone_cnt != 1 || ld_adr_q.size() != NLD || sk_adr_q.size() != NRD ||
        (ld_adr_q.size() > 0 && ld_adr_q[0] !== 22'd0)) begin
      errors++;
      $display("FAIL restart_frame got done=%0d loads=%0d stores=%0d want 1 %0d %0d",
               fdone_cnt, ld_adr_q.size(), sk_adr_q.size(), NLD, NRD);
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    int nl, ns;
    for (int i = 0; i < NLD; i++) src_mem[i] = $urandom;
    for (int i = 0; i < NRD; i++) res_mem[i] = $urandom;
    clear_logs();
    delay_mode = 2; withhold_adr = -1; spurious = 0; go_in_run = 0;
    go_i = 1'b1;
    n = 0;
    while (!(stb_o === 1'b1 && we_o === 1'b0) && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (stb_o !== 1'b1 || we_o !== 1'b0) begin
      errors++;
      $display("FAIL reach_read got stb=%b we=%b want 1 0", stb_o, we_o);
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL mid_reset_outs got %h want 0", all_outs);
    end
    nl = ld_adr_q.size();
    ns = sk_adr_q.size();
    repeat (10) begin
      step();
      checks++;
      if (busy_o !== 1'b0 || cyc_o !== 1'b0 || stb_o !== 1'b0 || snk_we_o !== 1'b0 ||
          src_rd_o !== 1'b0 || ld_adr_q.size() != nl || sk_adr_q.size() != ns) begin
        errors++;
        $display("FAIL post_reset_quiet got busy=%b cyc=%b stb=%b snk_we=%b src_rd=%b want 0",
                 busy_o, cyc_o, stb_o, snk_we_o, src_rd_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame("basic", 0, 1'b0, 1'b0);
    test_frame("ack_delay3", 3, 1'b0, 1'b0);
    test_frame("random_go_in_run", -1, 1'b1, 1'b1);
    test_frame("random_back_to_back", -1, 1'b0, 1'b0);
    test_timeout();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_frame_sequencer.md
SOBEL_FRAME_SEQUENCER -- requirements
Module: sobel_frame_sequencer

Interface
REQ-001 Parameter LOAD_LAST_ADR, default 22'h4B000, byte address of the final word written into the sobel engine.
REQ-002 Parameter READ_LAST_ADR, default 22'h4AB00, byte address of the final result word read back.
REQ-003 Parameter ACK_TIMEOUT, default 255, maximum cycles an outstanding strobe may wait for ack_i.
REQ-004 The block SHALL use one clock, clk_i; reset rst_i is synchronous and active-high.
REQ-005 Ports, in order:
 clk_i  in  1  clock
 rst_i  in  1  synchronous active-high reset
 go_i  in  1  frame request pulse
 busy_o  out  1  sequence in progress
 frame_done_o  out  1  one-cycle completion pulse
 err_o  out  1  sticky ack-timeout flag
 cyc_o  out  1  bus cycle to sobel
 stb_o  out  1  bus strobe to sobel
 we_o  out  1  1 = load phase, 0 = readback phase
 adr_o  out  22  sobel byte address
 dat_o  out  32  write data to sobel
 dat_i  in  32  read data from sobel
 ack_i  in  1  sobel acknowledge
 start_o  out  1  sobel processing request
 done_i  in  1  sobel processing complete
 src_rd_o  out  1  source frame memory read strobe
 src_adr_o  out  22  source byte address
 src_dat_i  in  32  source data, valid the cycle after src_rd_o
 snk_we_o  out  1  result memory write strobe
 snk_adr_o  out  22  result byte address
 snk_dat_o  out  32  result data

Function
REQ-006 States SHALL be IDLE, LD_FETCH, LD_WAIT, LD_REQ, RUN, RD_REQ, RD_STORE, DONE and ERR.
REQ-007 IDLE: go_i=1 -> LD_FETCH, address counter = 0, err_o cleared; go_i SHALL be ignored in every other state.
REQ-008 LD_FETCH: src_rd_o=1 and src_adr_o=counter for exactly one cycle -> LD_WAIT.
REQ-009 LD_WAIT: dat_o <= src_dat_i; cyc_o=1 -> LD_REQ.
REQ-010 LD_REQ: cyc_o=1, stb_o=1, we_o=1, adr_o=counter; stb_o, adr_o and dat_o SHALL stay stable until ack_i=1.
REQ-011 On ack in LD_REQ: stb_o drops the next cycle; counter == LOAD_LAST_ADR -> RUN with cyc_o=0 and counter=0; otherwise counter += 4 -> LD_FETCH with cyc_o held at 1.
REQ-012 RUN: start_o=1 until done_i is sampled high; then start_o=0 -> RD_REQ.
REQ-013 RD_REQ: cyc_o=1, stb_o=1, we_o=0, adr_o=counter until ack_i; on ack, capture dat_i -> RD_STORE.
REQ-014 RD_STORE: snk_we_o=1 for one cycle with snk_adr_o=counter and snk_dat_o=captured word, stb_o=0.
REQ-015 After RD_STORE: counter == READ_LAST_ADR -> DONE with cyc_o=0; otherwise counter += 4 -> RD_REQ.
REQ-016 DONE: frame_done_o=1 for one cycle -> IDLE.
REQ-017 busy_o SHALL be 1 in every state except IDLE and ERR.
REQ-018 A wait counter SHALL reset on entry to LD_REQ or RD_REQ; if ACK_TIMEOUT cycles elapse without ack_i, the block -> ERR.
REQ-019 ERR: cyc_o=stb_o=start_o=0 and err_o=1; go_i -> LD_FETCH with err_o cleared and counter=0.
REQ-020 ack_i outside LD_REQ/RD_REQ SHALL be ignored; done_i outside RUN SHALL be ignored.
REQ-021 The address counter SHALL be 22-bit, step 4, and never wrap, because the last-address compare precedes increment.
REQ-022 A frame SHALL transfer LOAD_LAST_ADR/4+1 words in (76801 at default) and READ_LAST_ADR/4+1 words out (76481 at default).

Reset
REQ-023 rst_i sampled high SHALL force IDLE, counter=0, and every output to 0 on the next edge, including mid-frame; no further bus or sink strobes follow.
REQ-024 After reset release, the first frame SHALL begin only on a new go_i.

Verification (LOAD_LAST_ADR=12, READ_LAST_ADR=8, ACK_TIMEOUT=8)
REQ-025 go_i pulse, sobel acks in 1 cycle, src word = address -> four writes at adr 0,4,8,12 with dat_o 0,4,8,12; then start_o=1.
REQ-026 done_i raised 5 cycles after start_o -> start_o low next cycle; three reads at 0,4,8; snk_we_o three times with matching data; frame_done_o pulses once; busy_o=0.
REQ-027 ack delayed 3 cycles on every beat -> stb_o, adr_o and dat_o held constant for the whole wait; result identical to REQ-025.
REQ-028 ack withheld on load beat 2 -> after 8 cycles, ERR with err_o=1, cyc_o=0; a later go_i restarts at adr 0 with err_o=0.
REQ-029 rst_i asserted during RD_REQ -> next cycle all outputs 0, state IDLE; go_i during RUN has no effect.
